vadd_arbiter: RTL and testbench
===============================

Name: vadd_arbiter

Overview:
- Round-robin scheduler that shares one 4-lane x 16-bit lane-adder datapath (64 bits per pass) among NREQ vector-add requesters.
- Per granted request: captures both 256-bit operand vectors, runs 4 serial passes of 64 bits each, assembles the 256-bit sum and 16 lane overflow flags, then pulses done tagged with the owner id.
- Sits between the vector issue ports and the lane-adder bank. The adder bank is external and purely combinational.

Parameters:
- NREQ, 2, number of requesters (legal range 2..4).
- IDW, 2, width of done_id; must satisfy 2^IDW >= NREQ.

Ports:
- clk1  in  1  single clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk1.
- req  in  NREQ  level request, one bit per requester.
- in1_flat  in  NREQ*256  operand A; requester i uses bits [256*i +: 256].
- in2_flat  in  NREQ*256  operand B, same packing as in1_flat.
- gnt  out  NREQ  one-hot, one-cycle pulse marking the cycle in which operands were captured.
- busy  out  1  high in any state other than IDLE.
- add_a  out  64  adder operand A for the current pass.
- add_b  out  64  adder operand B for the current pass.
- add_sum  in  64  combinational sum from the adder bank.
- add_ovf  in  4  per-lane signed-overflow flags from the adder bank.
- sum_out  out  256  assembled result; held until the next done.
- ovf_lanes  out  16  per-lane overflow; bit j belongs to lane j (bits [16j +: 16]).
- ovf_out  out  1  OR of ovf_lanes.
- done  out  1  one-cycle result-valid pulse.
- done_id  out  IDW  index of the requester that owns sum_out.

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, gnt=0, done=0, busy=0, sum_out=0, ovf_lanes=0, done_id=0, rr pointer=0. Reset mid-operation aborts the operation with no done pulse and no partial result.
- States: IDLE, P0, P1, P2, P3, DONE. All outputs are registered except add_a and add_b.
- IDLE: if any req bit is high, choose the winner by round-robin, searching from index ptr upward with wrap. On the clock edge:
  - capture the winner's in1/in2 into 256-bit operand registers;
  - assert gnt[winner] for the next cycle only;
  - latch owner = winner and set ptr = winner+1 mod NREQ;
  - go to P0.
  - With no request, stay in IDLE.
- Pk (k=0..3):
  - add_a = opA[64k +: 64] and add_b = opB[64k +: 64], combinationally from state.
  - At the edge, capture add_sum into a staging sum[64k +: 64] and add_ovf into staging ovf[4k +: 4].
  - Transitions: Pk -> Pk+1; P3 -> DONE.
- DONE:
  - done=1, done_id=owner.
  - sum_out and ovf_lanes update to the staging values in the same cycle that done rises.
  - Next state: IDLE.
- add_a and add_b are 0 in IDLE and DONE.
- Timing: gnt high in cycle G; P0..P3 occupy cycles G..G+3; done is high in cycle G+4. Throughput is one operation per 6 cycles.
- req is level-sensitive and is not cleared by the block. A requester that keeps req high after gnt is treated as issuing a new request and competes again under round-robin.
- Operand inputs are sampled only in the capture cycle. Changes on in1/in2 during P0..P3 have no effect.
- Simultaneous requests: exactly one grant per arbitration; the rr pointer guarantees that a pending requester is served within NREQ operations.
- Requester indices >= NREQ do not exist; req width is exactly NREQ.

Optional Feature:
- Macro: VADD_ARB_B2B_EN.
- Defined:
  - In DONE, arbitration runs exactly as in IDLE. If any req is high, operands are captured and gnt pulses in the cycle after DONE, and the next state is P0, so IDLE is skipped.
  - Throughput becomes one operation per 5 cycles. done and the new gnt are never high in the same cycle.
- Undefined: DONE always returns to IDLE.

Test Plan:
- Single request, vector add:
  - Stimulus: req=01; all 16 lanes of in1 and in2 = 0x533a.
  - Response: gnt=01 for one cycle; done 4 cycles later with done_id=0; every lane of sum_out = 0xa674; ovf_lanes=0xffff; ovf_out=1.
- Simultaneous requests:
  - Stimulus: req=11 held; in1 lanes for requester 0 = 0x0001, for requester 1 = 0x0002; in2 lanes = 0x0001 for both.
  - Response: grants alternate 01, 10, 01; done_id alternates 0, 1, 0; sums are 0x0002 (requester 0) and 0x0003 (requester 1); ovf_out=0.
- Pass ordering:
  - Stimulus: in1 has lane j = j; in2 = 0.
  - Response: add_a carries lanes 0-3 in P0 and lanes 12-15 in P3; sum_out lane j = j.
- Reset mid-operation:
  - Stimulus: drop rst_n during P2.
  - Response: next cycle state=IDLE; busy=0; done is never pulsed; sum_out=0; after release, req=10 is granted to requester 1 first.
- Operand stability:
  - Stimulus: change in1 in P1 of an operation.
  - Response: sum_out reflects the operands captured at gnt only.
- Back-to-back (VADD_ARB_B2B_EN defined):
  - Stimulus: req=01 held.
  - Response: done pulses every 5 cycles.
  - Without the macro, the same stimulus gives done every 6 cycles.

Source files
------------

// File: rtl/vadd_arbiter.sv
// Round-robin scheduler sharing one 4-lane x 16-bit adder among NREQ vector-add requesters.
// Optional back-to-back arbitration from DONE is enabled by defining VADD_ARB_B2B_EN.
module vadd_arbiter #(
  parameter int NREQ = 2,
  parameter int IDW  = 2
) (
  input  logic                clk1,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*256-1:0] in1_flat,
  input  logic [NREQ*256-1:0] in2_flat,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic [63:0]         add_a,
  output logic [63:0]         add_b,
  input  logic [63:0]         add_sum,
  input  logic [3:0]          add_ovf,
  output logic [255:0]        sum_out,
  output logic [15:0]         ovf_lanes,
  output logic                ovf_out,
  output logic                done,
  output logic [IDW-1:0]      done_id
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_P0   = 3'd1,
    ST_P1   = 3'd2,
    ST_P2   = 3'd3,
    ST_P3   = 3'd4,
    ST_DONE = 3'd5
  } state_t;

  state_t          state_r, state_nx_s;
  logic [IDW-1:0]  ptr_r, owner_r, ptr_nx_s;
  logic [IDW-1:0]  hi_idx_s, lo_idx_s, win_idx_s;
  logic            hi_found_s, lo_found_s, win_found_s, take_s;
  logic [NREQ-1:0] gnt_nx_s, gnt_r;
  logic [255:0]    win_a_s, win_b_s, opa_r, opb_r;
  logic [255:0]    sum_stage_r, sum_full_s, sum_out_r;
  logic [15:0]     ovf_stage_r, ovf_full_s, ovf_lanes_r;
  logic            busy_r, ovf_out_r, done_r;
  logic [IDW-1:0]  done_id_r;

  // Round-robin pick: lowest requester at or above ptr, else lowest overall (wrap)
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_idx_s   = {IDW{1'b0}};
    lo_idx_s   = {IDW{1'b0}};
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i] && (i >= int'(ptr_r))) begin
        hi_found_s = 1'b1;
        hi_idx_s   = IDW'(i);
      end else begin
        hi_found_s = hi_found_s;
      end
      if (req[i]) begin
        lo_found_s = 1'b1;
        lo_idx_s   = IDW'(i);
      end else begin
        lo_found_s = lo_found_s;
      end
    end
    win_found_s = lo_found_s;
    if (hi_found_s) begin
      win_idx_s = hi_idx_s;
    end else begin
      win_idx_s = lo_idx_s;
    end
    if (win_idx_s == IDW'(NREQ - 1)) begin
      ptr_nx_s = {IDW{1'b0}};
    end else begin
      ptr_nx_s = win_idx_s + IDW'(1'b1);
    end
  end

  // Winner's operand slices and one-hot grant vector
  always_comb begin
    win_a_s  = 256'd0;
    win_b_s  = 256'd0;
    gnt_nx_s = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx_s == IDW'(i)) begin
        win_a_s     = in1_flat[256*i +: 256];
        win_b_s     = in2_flat[256*i +: 256];
        gnt_nx_s[i] = 1'b1;
      end else begin
        gnt_nx_s[i] = 1'b0;
      end
    end
  end

  // Next-state logic; take_s marks an operand-capture edge
  always_comb begin
    state_nx_s = state_r;
    take_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (win_found_s) begin
          state_nx_s = ST_P0;
          take_s     = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_P0:   state_nx_s = ST_P1;
      ST_P1:   state_nx_s = ST_P2;
      ST_P2:   state_nx_s = ST_P3;
      ST_P3:   state_nx_s = ST_DONE;
      ST_DONE: begin
`ifdef VADD_ARB_B2B_EN
        if (win_found_s) begin
          state_nx_s = ST_P0;
          take_s     = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
        end
`else
        state_nx_s = ST_IDLE;
`endif
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Adder operands for the current pass and the staging image including this pass
  always_comb begin
    add_a      = 64'd0;
    add_b      = 64'd0;
    sum_full_s = sum_stage_r;
    ovf_full_s = ovf_stage_r;
    case (state_r)
      ST_P0: begin
        add_a = opa_r[63:0];    add_b = opb_r[63:0];
        sum_full_s[63:0] = add_sum;    ovf_full_s[3:0] = add_ovf;
      end
      ST_P1: begin
        add_a = opa_r[127:64];  add_b = opb_r[127:64];
        sum_full_s[127:64] = add_sum;  ovf_full_s[7:4] = add_ovf;
      end
      ST_P2: begin
        add_a = opa_r[191:128]; add_b = opb_r[191:128];
        sum_full_s[191:128] = add_sum; ovf_full_s[11:8] = add_ovf;
      end
      ST_P3: begin
        add_a = opa_r[255:192]; add_b = opb_r[255:192];
        sum_full_s[255:192] = add_sum; ovf_full_s[15:12] = add_ovf;
      end
      default: begin
        add_a = 64'd0;
        add_b = 64'd0;
      end
    endcase
  end

  // State, operand capture, staging and registered outputs
  always_ff @(posedge clk1) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      ptr_r       <= {IDW{1'b0}};
      owner_r     <= {IDW{1'b0}};
      gnt_r       <= {NREQ{1'b0}};
      busy_r      <= 1'b0;
      opa_r       <= 256'd0;
      opb_r       <= 256'd0;
      sum_stage_r <= 256'd0;
      ovf_stage_r <= 16'd0;
      sum_out_r   <= 256'd0;
      ovf_lanes_r <= 16'd0;
      ovf_out_r   <= 1'b0;
      done_r      <= 1'b0;
      done_id_r   <= {IDW{1'b0}};
    end else begin
      state_r     <= state_nx_s;
      busy_r      <= (state_nx_s != ST_IDLE);
      sum_stage_r <= sum_full_s;
      ovf_stage_r <= ovf_full_s;
      if (take_s) begin
        opa_r   <= win_a_s;
        opb_r   <= win_b_s;
        owner_r <= win_idx_s;
        ptr_r   <= ptr_nx_s;
        gnt_r   <= gnt_nx_s;
      end else begin
        gnt_r   <= {NREQ{1'b0}};
      end
      if (state_r == ST_P3) begin
        done_r      <= 1'b1;
        done_id_r   <= owner_r;
        sum_out_r   <= sum_full_s;
        ovf_lanes_r <= ovf_full_s;
        ovf_out_r   <= |ovf_full_s;
      end else begin
        done_r      <= 1'b0;
      end
    end
  end

  assign gnt       = gnt_r;
  assign busy      = busy_r;
  assign sum_out   = sum_out_r;
  assign ovf_lanes = ovf_lanes_r;
  assign ovf_out   = ovf_out_r;
  assign done      = done_r;
  assign done_id   = done_id_r;

endmodule

// File: tb/tb_vadd_arbiter.sv
// Randomized self-checking bench for vadd_arbiter against a cycle-level behavioural model.
module tb_vadd_arbiter;
  localparam int NREQ = 2;
  localparam int IDW  = 2;
`ifdef VADD_ARB_B2B_EN
  localparam int PERIOD = 5;
  localparam bit B2B    = 1'b1;
`else
  localparam int PERIOD = 6;
  localparam bit B2B    = 1'b0;
`endif

  logic                clk1 = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [NREQ*256-1:0] in1_flat, in2_flat;
  logic [NREQ-1:0]     gnt;
  logic                busy, ovf_out, done;
  logic [63:0]         add_a, add_b, add_sum;
  logic [3:0]          add_ovf;
  logic [255:0]        sum_out;
  logic [15:0]         ovf_lanes;
  logic [IDW-1:0]      done_id;

  always #5 clk1 = ~clk1;

  vadd_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk1(clk1), .rst_n(rst_n), .req(req), .in1_flat(in1_flat), .in2_flat(in2_flat),
    .gnt(gnt), .busy(busy), .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
    .add_ovf(add_ovf), .sum_out(sum_out), .ovf_lanes(ovf_lanes), .ovf_out(ovf_out),
    .done(done), .done_id(done_id)
  );

  // External combinational lane-adder bank
  always_comb begin
    add_sum = 64'd0;
    add_ovf = 4'd0;
    for (int j = 0; j < 4; j++) begin
      add_sum[16*j +: 16] = add_a[16*j +: 16] + add_b[16*j +: 16];
      add_ovf[j] = (add_a[16*j+15] == add_b[16*j+15]) && (add_sum[16*j+15] != add_a[16*j+15]);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference arithmetic: signed lane add, overflow when the true sum leaves 16-bit range
  function automatic void lane_add(input logic [255:0] a, input logic [255:0] b,
                                   output logic [255:0] s, output logic [15:0] o);
    int r;
    s = 256'd0;
    o = 16'd0;
    for (int j = 0; j < 16; j++) begin
      r = int'($signed(a[16*j +: 16])) + int'($signed(b[16*j +: 16]));
      s[16*j +: 16] = r[15:0];
      o[j] = (r > 32767) || (r < -32768);
    end
  endfunction

  // Model: phase -1 idle, 0..3 passes, 4 done
  int           m_phase = -1;
  int           m_ptr   = 0;
  int           m_owner = 0;
  int           m_done_id = 0;
  logic [255:0] m_a = 256'd0, m_b = 256'd0, m_sum_out = 256'd0;
  logic [15:0]  m_ovf = 16'd0;
  int           cyc = 0;
  int           last_done = -1;
  bit           track_iv = 1'b0;

  task automatic step();
    logic                p_rst;
    logic [NREQ-1:0]     p_req, egnt;
    logic [NREQ*256-1:0] p1, p2;
    logic [255:0]        s, sh_a, sh_b;
    logic [15:0]         o;
    int                  w, idx;
    p_rst = rst_n; p_req = req; p1 = in1_flat; p2 = in2_flat;
    @(posedge clk1);
    #1;
    cyc++;
    egnt = '0;
    if (!p_rst) begin
      m_phase = -1; m_ptr = 0; m_owner = 0; m_done_id = 0;
      m_sum_out = 256'd0; m_ovf = 16'd0;
    end else begin
      if (m_phase >= 0 && m_phase < 4) begin
        m_phase++;
      end else begin
        w = -1;
        if (m_phase == -1 || B2B) begin
          for (int k = 0; k < NREQ; k++) begin
            idx = (m_ptr + k) % NREQ;
            if (w < 0 && ((p_req >> idx) & NREQ'(1)) != '0) w = idx;
          end
        end
        if (w >= 0) begin
          m_phase = 0; m_owner = w; m_ptr = (w + 1) % NREQ;
          m_a = p1[256*w +: 256];
          m_b = p2[256*w +: 256];
          egnt = NREQ'(1) << w;
        end else begin
          m_phase = -1;
        end
      end
      if (m_phase == 4) begin
        lane_add(m_a, m_b, s, o);
        m_sum_out = s; m_ovf = o; m_done_id = m_owner;
      end
    end
    sh_a = 256'd0; sh_b = 256'd0;
    if (m_phase >= 0 && m_phase < 4) begin
      sh_a = m_a >> (64 * m_phase);
      sh_b = m_b >> (64 * m_phase);
    end
    check_eq("gnt", 256'(gnt), 256'(egnt));
    check_eq("busy", 256'(busy), 256'(m_phase != -1));
    check_eq("done", 256'(done), 256'(m_phase == 4));
    check_eq("add_a", 256'(add_a), 256'(sh_a[63:0]));
    check_eq("add_b", 256'(add_b), 256'(sh_b[63:0]));
    check_eq("sum_out", sum_out, m_sum_out);
    check_eq("ovf_lanes", 256'(ovf_lanes), 256'(m_ovf));
    check_eq("ovf_out", 256'(ovf_out), 256'(|m_ovf));
    check_eq("done_id", 256'(done_id), 256'(m_done_id));
    if (done === 1'b1) begin
      if (track_iv && last_done >= 0) check_eq("done_interval", 256'(cyc - last_done), 256'(PERIOD));
      last_done = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0;
    run(2);
    rst_n = 1'b1;
  endtask

  task automatic set_lanes(input int r, input logic [15:0] v1, input logic [15:0] v2);
    for (int j = 0; j < 16; j++) begin
      in1_flat[256*r + 16*j +: 16] = v1;
      in2_flat[256*r + 16*j +: 16] = v2;
    end
  endtask

  task automatic randomize_ops();
    for (int i = 0; i < NREQ * 8; i++) begin
      in1_flat[32*i +: 32] = $urandom();
      in2_flat[32*i +: 32] = $urandom();
    end
  endtask

  logic [255:0] kexp;

  initial begin
    rst_n = 1'b0; req = '0; in1_flat = '0; in2_flat = '0;
    do_reset();

    // Single request, 0x533a + 0x533a in every lane
    set_lanes(0, 16'h533a, 16'h533a);
    req = 2'b01; run(1);
    req = 2'b00; run(8);
    for (int j = 0; j < 16; j++) kexp[16*j +: 16] = 16'ha674;
    check_eq("tp_sum_a674", sum_out, kexp);
    check_eq("tp_ovf_lanes", 256'(ovf_lanes), 256'(16'hffff));
    check_eq("tp_ovf_out", 256'(ovf_out), 256'(1'b1));

    // Simultaneous requests alternate under round-robin
    do_reset();
    set_lanes(0, 16'h0001, 16'h0001);
    set_lanes(1, 16'h0002, 16'h0001);
    req = 2'b11; run(20);
    req = 2'b00; run(8);

    // Pass ordering: lane j carries j
    do_reset();
    in1_flat = '0; in2_flat = '0;
    for (int j = 0; j < 16; j++) in1_flat[16*j +: 16] = 16'(j);
    req = 2'b01; run(1);
    req = 2'b00; run(8);
    for (int j = 0; j < 16; j++) kexp[16*j +: 16] = 16'(j);
    check_eq("tp_lane_order", sum_out, kexp);

    // Reset during P2, then requester 1 alone
    do_reset();
    randomize_ops();
    req = 2'b01; run(1);
    req = 2'b00;
    for (int i = 0; i < 6 && m_phase != 2; i++) step();
    rst_n = 1'b0; run(1);
    check_eq("rst_mid_sum", sum_out, 256'd0);
    rst_n = 1'b1; req = 2'b10; run(1);
    req = 2'b00; run(8);

    // Operand change during P1 is ignored
    do_reset();
    randomize_ops();
    req = 2'b01; run(1);
    req = 2'b00; run(1);
    randomize_ops();
    run(8);

    // Held request: done period
    do_reset();
    randomize_ops();
    track_iv = 1'b1; last_done = -1;
    req = 2'b01; run(40);
    req = 2'b00; run(8);
    track_iv = 1'b0;

    // Random traffic with occasional reset
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req = NREQ'($urandom_range(0, (1 << NREQ) - 1));
      randomize_ops();
      rst_n = ($urandom_range(0, 59) != 0);
      step();
    end
    rst_n = 1'b1; req = '0; run(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
